nb_b_compare_mon: RTL and testbench
===================================

// Module: nb_b_compare_mon
// PURPOSE
//  Downstream checker for the blocking/non-blocking example design. Registers the
//  non-blocking pipeline outputs {x,y,z} and the blocking outputs {xb,yb,zb} every
//  clock and compares them bitwise over a fixed window started by 'start'.
//  Reports a mismatch count, and the index and bit pattern of the first mismatch.
// PARAMETERS
//  WINDOW  16  samples compared per run; 1 <= WINDOW <= 2**IDX_W
//  CNT_W   8   width of mism_cnt; saturates at 2**CNT_W-1
//  IDX_W   4   width of the sample index and first_idx
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  start       in   1      begin a run; sampled in IDLE/DONE, ignored in RUN
//  clr         in   1      sync clear to IDLE, results zeroed; wins over start
//  x,y,z       in   1 ea   non-blocking pipeline outputs of the upstream design
//  xb,yb,zb    in   1 ea   blocking pipeline outputs of the upstream design
//  busy        out  1      high while in RUN
//  done        out  1      high while in DONE; results valid
//  mismatch    out  1      sticky: >=1 mismatch in the current/last run
//  mism_cnt    out  CNT_W  number of mismatching samples, saturating
//  first_idx   out  IDX_W  sample index of the first mismatch
//  first_diff  out  3      {x^xb,y^yb,z^zb} at the first mismatch
//  cur_diff    out  3      diff vector of the registered inputs, free-running
//  hist_diff   out  12     last 4 mismatch diff vectors (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE; input regs, sample index, and all outputs 0.
//  - Input stage: all six inputs registered on every edge, independent of state.
//    diff = {x_r^xb_r, y_r^yb_r, z_r^zb_r}. cur_diff = diff, registered (1-cycle lag).
//  - FSM states: IDLE, RUN, DONE.
//    IDLE --start--> RUN: zero mism_cnt, mismatch, first_idx, first_diff, idx.
//    RUN: each edge evaluates diff for sample idx. If diff!=0: mism_cnt+1 (hold at
//      max), and if mismatch==0 then set mismatch, first_idx=idx, first_diff=diff.
//      At idx==WINDOW-1 -> DONE; otherwise idx+1.
//    DONE: hold all results. start -> RUN with the same zeroing as IDLE.
//    clr in any state -> IDLE, results zeroed. clr and start together -> IDLE.
//  - Timing: start seen at edge E0 (state IDLE/DONE). Sample k = inputs registered
//    at edge E0+k, evaluated at edge E0+k+1, k=0..WINDOW-1. busy is high after E0
//    through E0+WINDOW; done is high from after E0+WINDOW until the next start/clr/rst.
//  - start during RUN is ignored; the run is not restarted.
//  - Reset mid-RUN aborts immediately; no partial results are kept.
//  - Saturation: at mism_cnt == 2**CNT_W-1, further mismatches leave it unchanged;
//    mismatch stays 1.
// CONFIGURATION
//  Macro CMP_HISTORY_EN.
//  Defined: a 4-entry shift register of 3-bit diff vectors is built. On every RUN
//    edge with diff!=0, the newest entry is shifted into hist_diff[2:0] and older
//    entries move up; [11:9] holds the oldest. Zeroed on rst, clr, and run start.
//  Not defined: the history register is not built; hist_diff is tied to 12'h000.
//    The port is present either way.
// TESTING
//  1 rst=1 for 2 clks, random inputs -> all outputs 0, busy=0, done=0.
//  2 WINDOW=8, inputs x=xb,y=yb,z=zb, start pulse -> busy 8 cycles, then done=1,
//    mism_cnt=0, mismatch=0.
//  3 WINDOW=8, y!=yb only on sample 3 -> mism_cnt=1, first_idx=3,
//    first_diff=3'b010, mismatch=1.
//  4 CNT_W=3, IDX_W=4, WINDOW=16, x!=xb every sample -> mism_cnt=7 (saturated),
//    first_idx=0, first_diff=3'b100.
//  5 rst pulse at RUN sample 4 -> all outputs 0 at once, IDLE. Then clr+start in
//    the same cycle -> stays IDLE, busy=0.
//  6 CMP_HISTORY_EN, mismatch diffs 001,010,100,111,011 in order ->
//    hist_diff={3'b010,3'b100,3'b111,3'b011}. Without the macro -> hist_diff=0.

Source files
------------

// File: rtl/nb_b_compare_mon_if.sv
// rtl/nb_b_compare_mon_if.sv - control, sample and result signals of the nb/blocking compare monitor
// master drives start/clr and the six pipeline outputs; slave is the monitor.
interface nb_b_compare_mon_if #(
  parameter int CNT_W = 8,
  parameter int IDX_W = 4
);
  logic             start;
  logic             clr;
  logic             x, y, z;
  logic             xb, yb, zb;
  logic             busy;
  logic             done;
  logic             mismatch;
  logic [CNT_W-1:0] mism_cnt;
  logic [IDX_W-1:0] first_idx;
  logic [2:0]       first_diff;
  logic [2:0]       cur_diff;
  logic [11:0]      hist_diff;

  modport master (
    output start, clr, x, y, z, xb, yb, zb,
    input  busy, done, mismatch, mism_cnt, first_idx, first_diff, cur_diff, hist_diff
  );

  modport slave (
    input  start, clr, x, y, z, xb, yb, zb,
    output busy, done, mismatch, mism_cnt, first_idx, first_diff, cur_diff, hist_diff
  );
endinterface

// File: rtl/nb_b_compare_mon.sv
// rtl/nb_b_compare_mon.sv - windowed bitwise compare of non-blocking vs blocking pipeline outputs
// Optional mismatch history register built when CMP_HISTORY_EN is defined.
module nb_b_compare_mon #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8,
  parameter int IDX_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  nb_b_compare_mon_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             x_r, y_r, z_r, xb_r, yb_r, zb_r;
  logic [2:0]       diff;
  logic [2:0]       cur_diff_r;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] mism_cnt_r;
  logic             mismatch_r;
  logic [IDX_W-1:0] first_idx_r;
  logic [2:0]       first_diff_r;
  logic             run_start;
  logic             last_sample;
  logic             clear_res;

  assign diff        = {x_r ^ xb_r, y_r ^ yb_r, z_r ^ zb_r};
  assign last_sample = (idx == IDX_W'(WINDOW - 1));
  assign clear_res   = bus.clr || run_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // clr outranks start in every state, so a simultaneous pair lands in IDLE
  always_comb begin
    state_nxt = state;
    run_start = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.clr) begin
          state_nxt = IDLE;
        end else if (bus.start) begin
          state_nxt = RUN;
          run_start = 1'b1;
        end
      end
      RUN: begin
        if (bus.clr)          state_nxt = IDLE;
        else if (last_sample) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {x_r, y_r, z_r, xb_r, yb_r, zb_r} <= '0;
      cur_diff_r   <= '0;
      idx          <= '0;
      mism_cnt_r   <= '0;
      mismatch_r   <= 1'b0;
      first_idx_r  <= '0;
      first_diff_r <= '0;
    end else begin
      {x_r, y_r, z_r}    <= {bus.x, bus.y, bus.z};
      {xb_r, yb_r, zb_r} <= {bus.xb, bus.yb, bus.zb};
      cur_diff_r         <= diff;
      if (clear_res) begin
        idx          <= '0;
        mism_cnt_r   <= '0;
        mismatch_r   <= 1'b0;
        first_idx_r  <= '0;
        first_diff_r <= '0;
      end else if (state == RUN) begin
        if (diff != 3'b000) begin
          if (mism_cnt_r != {CNT_W{1'b1}}) mism_cnt_r <= mism_cnt_r + 1'b1;
          if (!mismatch_r) begin
            mismatch_r   <= 1'b1;
            first_idx_r  <= idx;
            first_diff_r <= diff;
          end
        end
        if (!last_sample) idx <= idx + 1'b1;
      end
    end
  end

`ifdef CMP_HISTORY_EN
  logic [11:0] hist_r;

  // newest diff enters at [2:0]; the oldest of the four sits at [11:9]
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     hist_r <= '0;
    else if (clear_res)                          hist_r <= '0;
    else if (state == RUN && diff != 3'b000)     hist_r <= {hist_r[8:0], diff};
  end

  assign bus.hist_diff = hist_r;
`else
  assign bus.hist_diff = 12'h000;
`endif

  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.mismatch   = mismatch_r;
  assign bus.mism_cnt   = mism_cnt_r;
  assign bus.first_idx  = first_idx_r;
  assign bus.first_diff = first_diff_r;
  assign bus.cur_diff   = cur_diff_r;

endmodule

// File: tb/tb_nb_b_compare_mon.sv
// tb/tb_nb_b_compare_mon.sv - scoreboard bench for nb_b_compare_mon
// Expected results come from a per-run model over the chosen diff sequence.
module tb_nb_b_compare_mon;
  localparam int W     = 8;
  localparam int CNT_W = 3;
  localparam int IDX_W = 4;

  typedef logic [2:0] dvec_t [W];
  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic             mism;
    logic [IDX_W-1:0] fidx;
    logic [2:0]       fdiff;
    logic [11:0]      hist;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  exp_t sb[$];

  nb_b_compare_mon_if #(.CNT_W(CNT_W), .IDX_W(IDX_W)) bus ();

  nb_b_compare_mon #(.WINDOW(W), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t model(input dvec_t d);
    exp_t       e;
    int         n = 0;
    int         first = -1;
    logic [2:0] h[$];
    e.fdiff = 3'b000;
    e.hist  = 12'h000;
    for (int k = 0; k < W; k++) begin
      if (d[k] != 3'b000) begin
        n++;
        if (first < 0) begin
          first   = k;
          e.fdiff = d[k];
        end
        h.push_front(d[k]);
        if (h.size() > 4) void'(h.pop_back());
      end
    end
    e.cnt  = (n > 7) ? 3'd7 : CNT_W'(n);
    e.mism = (n > 0);
    e.fidx = (first < 0) ? '0 : IDX_W'(first);
`ifdef CMP_HISTORY_EN
    for (int i = 0; i < h.size(); i++) e.hist[3*i +: 3] = h[i];
`endif
    return e;
  endfunction

  task automatic drive_in(input logic [2:0] dd);
    logic [2:0] v;
    v = 3'($urandom);
    {bus.x, bus.y, bus.z}    = v;
    {bus.xb, bus.yb, bus.zb} = v ^ dd;
  endtask

  task automatic run_window(input dvec_t d, input bit mid_start);
    int c;
    sb.push_back(model(d));
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      bus.start = (k == 0) || (mid_start && k == 3);
      drive_in(d[k]);
    end
    @(negedge clk);
    bus.start = 1'b0;
    drive_in(3'($urandom));
    c = 0;
    while (!bus.done && c < 20) begin
      @(negedge clk);
      drive_in(3'($urandom));
      c++;
    end
    if (!bus.done) chk("done_timeout", 32'(bus.done), 32'd1);
  endtask

  // monitor: cur_diff lag check every cycle, result check when done rises
  initial begin : monitor
    logic [2:0] prev_in;
    bit         settle;
    bit         done_q;
    int         busy_len;
    exp_t       e;
    settle = 0; done_q = 0; busy_len = 0; prev_in = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        settle = 0; done_q = 0; busy_len = 0;
      end else begin
        if (settle) chk("cur_diff", 32'(bus.cur_diff), 32'(prev_in));
        prev_in = {bus.x ^ bus.xb, bus.y ^ bus.yb, bus.z ^ bus.zb};
        settle  = 1;
        if (bus.busy) busy_len++;
        if (bus.done && !done_q) begin
          chk("busy_len", 32'(busy_len), 32'(W));
          if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            chk("mism_cnt",   32'(bus.mism_cnt),   32'(e.cnt));
            chk("mismatch",   32'(bus.mismatch),   32'(e.mism));
            chk("first_idx",  32'(bus.first_idx),  32'(e.fidx));
            chk("first_diff", 32'(bus.first_diff), 32'(e.fdiff));
            chk("hist_diff",  32'(bus.hist_diff),  32'(e.hist));
          end
        end
        if (!bus.busy) busy_len = 0;
        done_q = bus.done;
      end
    end
  end

  initial begin : driver
    dvec_t d;
    bus.start = 1'b0;
    bus.clr   = 1'b0;
    drive_in(3'($urandom));

    repeat (2) begin
      @(negedge clk);
      drive_in(3'($urandom));
    end
    chk("rst_busy",     32'(bus.busy),       32'd0);
    chk("rst_done",     32'(bus.done),       32'd0);
    chk("rst_mism_cnt", 32'(bus.mism_cnt),   32'd0);
    chk("rst_mismatch", 32'(bus.mismatch),   32'd0);
    chk("rst_cur_diff", 32'(bus.cur_diff),   32'd0);
    chk("rst_hist",     32'(bus.hist_diff),  32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (d[k]) d[k] = 3'b000;
    run_window(d, 0);
    d[3] = 3'b010;
    run_window(d, 0);
    foreach (d[k]) d[k] = 3'b100;
    run_window(d, 0);
    d = '{3'b001, 3'b010, 3'b100, 3'b111, 3'b011, 3'b000, 3'b000, 3'b000};
    run_window(d, 1);
    repeat (10) begin
      foreach (d[k]) d[k] = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      run_window(d, $urandom_range(0, 1) == 1);
    end

    // clr while DONE zeroes results
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    chk("clr_done",     32'(bus.done),     32'd0);
    chk("clr_mism_cnt", 32'(bus.mism_cnt), 32'd0);
    chk("clr_mismatch", 32'(bus.mismatch), 32'd0);

    // reset mid-run
    @(negedge clk);
    bus.start = 1'b1;
    drive_in(3'b111);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) begin
      drive_in(3'b111);
      @(negedge clk);
    end
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_busy",       32'(bus.busy),       32'd0);
    chk("arst_done",       32'(bus.done),       32'd0);
    chk("arst_mism_cnt",   32'(bus.mism_cnt),   32'd0);
    chk("arst_mismatch",   32'(bus.mismatch),   32'd0);
    chk("arst_first_diff", 32'(bus.first_diff), 32'd0);
    chk("arst_cur_diff",   32'(bus.cur_diff),   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // clr and start together stay in IDLE
    @(negedge clk);
    bus.clr   = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.clr   = 1'b0;
    bus.start = 1'b0;
    chk("clrstart_busy", 32'(bus.busy), 32'd0);
    chk("clrstart_done", 32'(bus.done), 32'd0);

    d = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b110};
    run_window(d, 0);
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
